// File: rtl/mem_access_stage.sv
// mem_access_stage: post-ALU memory stage driving a req/gnt/rvalid data port and a registered writeback result
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_alu_out,
  input  logic [31:0] ex_rs2_data,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic [3:0]  ex_mem_op,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] wb_data,
  output logic        wb_misalign,
  output logic        wb_bus_err
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_n;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [4:0]  rd;
  logic        rw;
  logic [31:0] cnt;
  logic        accept, in_mem, in_mis, is_store, timeout;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  // Decode of the incoming op, store lane steering and load extraction
  always_comb begin
    accept   = ex_valid & ex_ready;
    in_mem   = ex_mem_op inside {[4'd1:4'd8]};
    in_mis   = ((ex_mem_op inside {4'd2, 4'd5, 4'd7}) & ex_alu_out[0]) |
               ((ex_mem_op inside {4'd3, 4'd8}) & |ex_alu_out[1:0]);
    is_store = op inside {[4'd6:4'd8]};
    timeout  = (TIMEOUT_CYCLES != 0) && (cnt + 32'd1 == TIMEOUT_CYCLES);
    st_data  = (ex_mem_op == 4'd6) ? {4{ex_rs2_data[7:0]}} :
               (ex_mem_op == 4'd7) ? {2{ex_rs2_data[15:0]}} : ex_rs2_data;
    st_be    = (ex_mem_op inside {4'd1, 4'd4, 4'd6}) ? 4'b0001 << ex_alu_out[1:0] :
               (ex_mem_op inside {4'd2, 4'd5, 4'd7}) ? (ex_alu_out[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    ld_byte  = dmem_rdata[{addr[1:0], 3'b000} +: 8];
    ld_half  = dmem_rdata[{addr[1], 4'b0000} +: 16];
    ld_data  = (op == 4'd1) ? {{24{ld_byte[7]}}, ld_byte} :
               (op == 4'd2) ? {{16{ld_half[15]}}, ld_half} :
               (op == 4'd4) ? {24'd0, ld_byte} :
               (op == 4'd5) ? {16'd0, ld_half} : dmem_rdata;
  end
  // State register; async reset drops dmem_req immediately
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  // Next-state logic
  always_comb begin
    state_n = state;
    if (state == IDLE && accept && in_mem && !in_mis) state_n = REQ;
    if (state == REQ && dmem_gnt) state_n = is_store ? IDLE : WAIT;
    if (state == WAIT && (dmem_rvalid || timeout)) state_n = IDLE;
  end
  // Handshake and memory-port outputs
  always_comb begin
    ex_ready   = state == IDLE;
    dmem_req   = state == REQ;
    dmem_we    = dmem_req & is_store;
    dmem_be    = dmem_req ? be : 4'd0;
    dmem_addr  = {addr[31:2], 2'b00};
    dmem_wdata = wdata;
  end
  // Access latch, watchdog counter and registered writeback pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {op, addr, wdata, be, rd, rw, cnt} <= '0;
      {wb_valid, wb_rd, wb_reg_write, wb_data, wb_misalign, wb_bus_err} <= '0;
    end else begin
      wb_valid <= 1'b0;
      if (state == IDLE && accept) begin
        if (!in_mem || in_mis) begin
          wb_valid     <= 1'b1;
          wb_rd        <= ex_rd;
          wb_reg_write <= ex_reg_write & !in_mis;
          wb_data      <= ex_alu_out;
          wb_misalign  <= in_mis;
          wb_bus_err   <= 1'b0;
        end else begin
          op    <= ex_mem_op;
          addr  <= ex_alu_out;
          wdata <= st_data;
          be    <= st_be;
          rd    <= ex_rd;
          rw    <= ex_reg_write;
        end
      end
      if (state == REQ && dmem_gnt) begin
        cnt <= '0;
        if (is_store) begin
          wb_valid     <= 1'b1;
          wb_rd        <= rd;
          wb_reg_write <= 1'b0;
          wb_data      <= addr;
          wb_misalign  <= 1'b0;
          wb_bus_err   <= 1'b0;
        end
      end
      if (state == WAIT) begin
        if (dmem_rvalid || timeout) begin
          wb_valid     <= 1'b1;
          wb_rd        <= rd;
          wb_reg_write <= dmem_rvalid & rw;
          wb_data      <= dmem_rvalid ? ld_data : addr;
          wb_misalign  <= 1'b0;
          wb_bus_err   <= !dmem_rvalid;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;
  logic        clk = 0, rst = 1;
  logic        ex_valid = 0, ex_reg_write = 0;
  logic [31:0] ex_alu_out = 0, ex_rs2_data = 0;
  logic [4:0]  ex_rd = 0;
  logic [3:0]  ex_mem_op = 0;
  logic        ex_ready, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt = 0, dmem_rvalid = 0;
  logic [31:0] dmem_rdata = 0;
  logic        wb_valid, wb_reg_write, wb_misalign, wb_bus_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int checks = 0, errors = 0;

  typedef struct {
    string       tag;
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
    logic        err;
  } exp_t;
  exp_t q[$];

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_alu_out(ex_alu_out), .ex_rs2_data(ex_rs2_data), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_op(ex_mem_op),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .wb_misalign(wb_misalign), .wb_bus_err(wb_bus_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic void push(input string tag, input logic [4:0] rd, input logic rw,
                               input logic [31:0] data, input logic chk_data,
                               input logic mis, input logic err);
    exp_t e;
    e.tag = tag; e.rd = rd; e.rw = rw; e.data = data;
    e.chk_data = chk_data; e.mis = mis; e.err = err;
    q.push_back(e);
  endfunction

  // Monitor: every writeback pulse is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wb: rd=%0d rw=%0b data=0x%08h mis=%0b err=%0b with nothing expected",
                 wb_rd, wb_reg_write, wb_data, wb_misalign, wb_bus_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (wb_rd !== e.rd || wb_reg_write !== e.rw || wb_misalign !== e.mis ||
            wb_bus_err !== e.err || (e.chk_data && wb_data !== e.data)) begin
          errors++;
          $display("FAIL wb_%s: got rd=%0d rw=%0b data=0x%08h mis=%0b err=%0b expected rd=%0d rw=%0b data=0x%08h mis=%0b err=%0b",
                   e.tag, wb_rd, wb_reg_write, wb_data, wb_misalign, wb_bus_err,
                   e.rd, e.rw, e.data, e.mis, e.err);
        end
      end
    end
  end

  // Presents one instruction for a single cycle; returns at the negedge after acceptance
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rw);
    @(negedge clk);
    ex_valid = 1; ex_mem_op = op; ex_alu_out = a; ex_rs2_data = rs2; ex_rd = rd; ex_reg_write = rw;
    @(negedge clk);
    ex_valid = 0;
  endtask

  task automatic load(input string tag, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] rdata, input logic [4:0] rd, input logic [31:0] exp,
                      input int rv_dly);
    push(tag, rd, 1'b1, exp, 1'b1, 1'b0, 1'b0);
    issue(op, a, 32'h0, rd, 1'b1);
    chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
    chk({tag, "_addr"}, dmem_addr, {a[31:2], 2'b00});
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    repeat (rv_dly) @(negedge clk);
    dmem_rvalid = 1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_rvalid = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ex_ready", {31'd0, ex_ready}, 32'd1);
    chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_data", wb_data, 32'h0);
    rst = 0;
    push("none", 5'd5, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    issue(4'd0, 32'h1234_5678, 32'h0, 5'd5, 1'b1);
    chk("none_ex_ready", {31'd0, ex_ready}, 32'd1);
    push("op9", 5'd7, 1'b0, 32'hCAFE_0001, 1'b1, 1'b0, 1'b0);
    issue(4'd9, 32'hCAFE_0001, 32'h0, 5'd7, 1'b0);
    push("sb", 5'd3, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'd6, 32'h0000_0103, 32'h0000_00AB, 5'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("sb_req", {31'd0, dmem_req}, 32'd1);
      chk("sb_we", {31'd0, dmem_we}, 32'd1);
      chk("sb_addr", dmem_addr, 32'h0000_0100);
      chk("sb_be", {28'd0, dmem_be}, 32'h8);
      chk("sb_wdata", dmem_wdata, 32'hABAB_ABAB);
      chk("sb_ex_ready", {31'd0, ex_ready}, 32'd0);
      if (i == 2) dmem_gnt = 1;
      @(negedge clk);
    end
    dmem_gnt = 0;
    chk("sb_req_done", {31'd0, dmem_req}, 32'd0);
    push("sh", 5'd4, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'd7, 32'h0000_0202, 32'h0000_BEEF, 5'd4, 1'b1);
    chk("sh_be", {28'd0, dmem_be}, 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    push("sw", 5'd6, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    issue(4'd8, 32'h0000_0304, 32'h1122_3344, 5'd6, 1'b1);
    chk("sw_be", {28'd0, dmem_be}, 32'hF);
    chk("sw_wdata", dmem_wdata, 32'h1122_3344);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    load("lb", 4'd1, 32'h0000_0101, 32'h0000_8000, 5'd8, 32'hFFFF_FF80, 0);
    load("lbu", 4'd4, 32'h0000_0101, 32'h0000_8000, 5'd9, 32'h0000_0080, 0);
    load("lh", 4'd2, 32'h0000_0102, 32'h8001_0000, 5'd10, 32'hFFFF_8001, 1);
    load("lhu", 4'd5, 32'h0000_0102, 32'h8001_0000, 5'd11, 32'h0000_8001, 0);
    load("lw", 4'd3, 32'h0000_0104, 32'hDEAD_BEEF, 5'd12, 32'hDEAD_BEEF, 2);
    load("lb_pos", 4'd1, 32'h0000_0100, 32'h0000_007F, 5'd13, 32'h0000_007F, 0);
    load("rv_at_limit", 4'd3, 32'h0000_0400, 32'h5555_AAAA, 5'd14, 32'h5555_AAAA, 3);
    push("lw_mis", 5'd15, 1'b0, 32'h0000_0102, 1'b1, 1'b1, 1'b0);
    issue(4'd3, 32'h0000_0102, 32'h0, 5'd15, 1'b1);
    chk("lw_mis_req", {31'd0, dmem_req}, 32'd0);
    chk("lw_mis_ex_ready", {31'd0, ex_ready}, 32'd1);
    push("sh_mis", 5'd16, 1'b0, 32'h0000_0201, 1'b1, 1'b1, 1'b0);
    issue(4'd7, 32'h0000_0201, 32'h0, 5'd16, 1'b1);
    chk("sh_mis_req", {31'd0, dmem_req}, 32'd0);
    push("bus_err", 5'd17, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    issue(4'd3, 32'h0000_0500, 32'h0, 5'd17, 1'b1);
    dmem_gnt = 1;
    @(negedge clk);
    dmem_gnt = 0;
    repeat (3) @(negedge clk);
    chk("bus_err_busy", {31'd0, ex_ready}, 32'd0);
    @(negedge clk);
    chk("bus_err_ex_ready", {31'd0, ex_ready}, 32'd1);
    dmem_rvalid = 1;
    @(negedge clk);
    dmem_rvalid = 0;
    chk("stray_rvalid_ex_ready", {31'd0, ex_ready}, 32'd1);
    issue(4'd8, 32'h0000_0600, 32'h0, 5'd18, 1'b0);
    chk("rst_mid_req_before", {31'd0, dmem_req}, 32'd1);
    #1 rst = 1;
    #1;
    chk("rst_mid_req", {31'd0, dmem_req}, 32'd0);
    chk("rst_mid_ex_ready", {31'd0, ex_ready}, 32'd1);
    @(negedge clk);
    rst = 0;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_req", {31'd0, dmem_req}, 32'd0);
    chk("pending_expectations", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
